input_capture: RTL and testbench
================================

Name: input_capture

Overview:
Input-capture unit: the measuring counterpart of the compare/IRQ timer. It times an external signal instead of generating timed events.
- Measures the period (like edge to like edge) or the pulse width (edge to opposite edge) of asynchronous input sig_in, in clk cycles.
- Latches each result with a one-cycle valid strobe and a sticky IRQ for the CPU-side register block.

Parameters:
WIDTH, 32, counter and capture register width
SYNC_STAGES, 2, synchronizer flops on sig_in (minimum 2)
FILT_LEN, 4, glitch-filter stability length in cycles (used only with INPUT_CAPTURE_FILTER_EN)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  1: capture enabled; 0: idle, measurement aborted
mode  in  1  0: period, 1: pulse width
pol  in  1  start edge: 0 rising, 1 falling
sig_in  in  1  asynchronous measured signal
irq_clr  in  1  one-cycle pulse; clears irq and ovf
cap_val  out  WIDTH  last captured measurement, in clk cycles
cap_valid  out  1  one-cycle strobe when cap_val updates
irq  out  1  sticky; set on capture or overflow
ovf  out  1  sticky; measurement exceeded 2^WIDTH-1 cycles
busy  out  1  1 while in MEASURE

Behaviour:
- Reset: all outputs 0; cnt=0; synchronizer and edge flops 0; state IDLE.
- Edge detection:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - An edge event is true in the cycle where the last sync flop differs from the history flop.
  - A sig_in change sampled at clk edge k makes registered outputs update at edge k+SYNC_STAGES.
- Edge roles:
  - start edge = pol edge.
  - end edge = pol edge in period mode; opposite edge in pulse mode.
- States:
  - IDLE: entered when en=0 (from any state, same cycle). cnt<=0. Edges ignored. en=1 -> ARM.
  - ARM: wait for a start edge. On start edge: cnt<=1 -> MEASURE. No capture from ARM.
  - MEASURE, end edge: cap_val<=cnt; cap_valid=1 for one cycle; irq<=1.
    - Period mode: cnt<=1, stay in MEASURE (end edge is the next start edge).
    - Pulse mode: -> ARM.
  - MEASURE, no end edge and cnt==all-ones: ovf<=1, irq<=1, no cap_valid, cap_val held, -> ARM.
  - MEASURE, otherwise: cnt<=cnt+1.
- Measurement result: start edge detected in cycle t0, end edge in cycle t0+P gives cap_val=P. Largest value captured without overflow is 2^WIDTH-1. cnt never wraps.
- Flags:
  - irq_clr clears irq and ovf.
  - A set in the same cycle as irq_clr wins (flag stays 1).
- en deassert mid-measurement: abort, no capture; cap_val, irq and ovf hold.
- Changing mode or pol while not in IDLE is undefined; software changes them only with en=0.
- busy=1 exactly while state==MEASURE.

Optional Feature:
INPUT_CAPTURE_FILTER_EN
- Defined:
  - A digital glitch filter sits between the synchronizer and edge detection.
  - The filtered level changes only after the synchronized level has differed from it for FILT_LEN consecutive cycles.
  - Shorter pulses are ignored.
  - Adds exactly FILT_LEN cycles of latency to every edge, so measured durations are unchanged.
- Undefined: no filter logic; the synchronizer output feeds edge detection directly; FILT_LEN is unused.

Test Plan:
1. Reset: assert rst_n=0 mid-measurement with sig_in toggling -> all outputs 0 immediately (asynchronous), state IDLE. After release with en=1, first capture requires two fresh edges.
2. Period: mode=0, pol=0, square wave with 10-cycle period -> first cap_valid after the 2nd rising edge, then one every 10 cycles, cap_val=10, irq=1, busy stays 1.
3. Pulse width: mode=1, high 7 / low 13 cycles -> pol=0 gives cap_val=7; pol=1 gives cap_val=13; cap_valid once per 20 cycles.
4. Overflow (WIDTH=8), mode=0:
   - Rising edges 255 cycles apart -> cap_val=255, ovf=0.
   - Single rising edge then none for 300 cycles -> ovf=1 and irq=1 256 cycles after the start edge, no cap_valid, busy=0.
5. Flags and abort:
   - irq_clr in the same cycle as cap_valid -> irq stays 1.
   - irq_clr alone -> irq=0, ovf=0.
   - en=0 for one cycle mid-measurement -> no capture for that period.
6. Filter (macro defined, FILT_LEN=4):
   - 2-cycle high glitch in pulse mode -> no capture.
   - 8-cycle high pulse -> cap_val=8, cap_valid 4 cycles later than without the macro.

Source files
------------

// File: rtl/input_capture.sv
// ============================================================================
// Module   : input_capture
// Purpose  : measures the period or pulse width of sig_in in clk cycles.
//            Optional glitch filter: define INPUT_CAPTURE_FILTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             pol,
  input  logic             sig_in,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_valid,
  output logic             irq,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   lvl;
  logic                   hist;
  logic                   rise;
  logic                   fall;
  logic                   start_edge;
  logic                   end_edge;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [WIDTH-1:0]       cnt;
  logic                   cap_now;
  logic                   ovf_now;
  logic                   cnt_clr;
  logic                   cnt_load;
  logic                   cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end
  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef INPUT_CAPTURE_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [FCW-1:0] filt_cnt;
  logic           filt_lvl;

  // Level follows sync_lvl only after FILT_LEN consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (sync_lvl != filt_lvl) begin
      if (filt_cnt == FCW'(FILT_LEN - 1)) begin
        filt_lvl <= sync_lvl;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end
  assign lvl = filt_lvl;
`else
  logic unused_filt;
  assign unused_filt = FILT_LEN[0];
  assign lvl = sync_lvl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b0;
    else        hist <= lvl;
  end

  assign rise       = lvl & ~hist;
  assign fall       = ~lvl & hist;
  assign start_edge = pol ? fall : rise;
  // In period mode the closing edge doubles as the next opening edge.
  assign end_edge   = mode ? (pol ? rise : fall) : start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_ARM;
        ST_ARM:     if (start_edge) state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (end_edge)            state_nxt = mode ? ST_ARM : ST_MEASURE;
          else if (cnt == CNT_MAX) state_nxt = ST_ARM;
        end
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cap_now  = 1'b0;
    ovf_now  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (!en || state == ST_IDLE) begin
      cnt_clr = 1'b1;
    end else if (state == ST_ARM) begin
      cnt_load = start_edge;
    end else if (state == ST_MEASURE) begin
      if (end_edge) begin
        cap_now  = 1'b1;
        cnt_load = 1'b1;
      end else if (cnt == CNT_MAX) begin
        ovf_now = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cap_val   <= '0;
      cap_valid <= 1'b0;
      irq       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (cnt_clr)       cnt <= '0;
      else if (cnt_load) cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      else if (cnt_inc)  cnt <= cnt + 1'b1;

      cap_valid <= cap_now;
      if (cap_now) cap_val <= cnt;

      // A set in the same cycle as irq_clr wins.
      if (cap_now || ovf_now) irq <= 1'b1;
      else if (irq_clr)       irq <= 1'b0;

      if (ovf_now)      ovf <= 1'b1;
      else if (irq_clr) ovf <= 1'b0;
    end
  end

  assign busy = (state == ST_MEASURE);

endmodule

`default_nettype wire

// File: tb/tb_input_capture.sv
// ============================================================================
// Module   : tb_input_capture
// Purpose  : directed, table-driven bench for input_capture (WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_input_capture;

  localparam int W = 8;
`ifdef INPUT_CAPTURE_FILTER_EN
  localparam int FLT = 4;
`else
  localparam int FLT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         pol = 1'b0;
  logic         sig_in = 1'b0;
  logic         irq_clr = 1'b0;
  logic [W-1:0] cap_val;
  logic         cap_valid;
  logic         irq;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  input_capture #(.WIDTH(W), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pol(pol),
    .sig_in(sig_in), .irq_clr(irq_clr), .cap_val(cap_val),
    .cap_valid(cap_valid), .irq(irq), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  m;
    logic  p;
    int    hi;
    int    lo;
    int    n;
    int    exp_val;
    int    exp_ncap;
    int    exp_first;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input logic m, input logic p);
    en = 1'b0; mode = m; pol = p; sig_in = 1'b0;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    repeat (8 + FLT) tick();
    en = 1'b1;
    tick();
    tick();
  endtask

  // Phase i is driven before clock edge i+1 and observed just after it.
  task automatic run_wave(input string name, input int hi, input int lo, input int n,
                          input int exp_val, input int clr_at, input int drop_at,
                          output int ncap, output int first);
    ncap = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      sig_in  = ((i % (hi + lo)) < hi);
      irq_clr = (i == clr_at);
      en      = (i != drop_at);
      tick();
      if (cap_valid) begin
        ncap++;
        if (first < 0) first = i;
        check({name, " cap_val"}, 64'(cap_val), 64'(exp_val));
      end
    end
    irq_clr = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    int   ncap, first;

    vecs[0] = '{"period_p0", 1'b0, 1'b0, 5, 5, 45, 10, 4, 12 + FLT};
    vecs[1] = '{"pulse_p0", 1'b1, 1'b0, 7, 13, 60, 7, 3, 9 + FLT};
    vecs[2] = '{"pulse_p1", 1'b1, 1'b1, 7, 13, 60, 13, 2, 22 + FLT};
    vecs[3] = '{"period_p1", 1'b0, 1'b1, 3, 9, 50, 12, 3, 17 + FLT};
    vecs[4] = '{"period_255", 1'b0, 1'b0, 5, 250, 520, 255, 2, 257 + FLT};
    vecs[5] = '{"pulse_8", 1'b1, 1'b0, 8, 30, 38 + FLT, 8, 1, 10 + FLT};

    // Reset state
    #3;
    check("rst cap_val", 64'(cap_val), 64'd0);
    check("rst flags", {cap_valid, irq, ovf, busy}, 4'b0000);
    #10 rst_n = 1'b1;

    // Asynchronous reset in the middle of a measurement
    prep(1'b0, 1'b0);
    run_wave("pre_rst", 5, 5, 17 + FLT, 10, -1, -1, ncap, first);
    check("pre_rst irq", irq, 1'b1);
    check("pre_rst busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async rst cap_val", 64'(cap_val), 64'd0);
    check("async rst flags", {cap_valid, irq, ovf, busy}, 4'b0000);
    #2 rst_n = 1'b1;
    prep(1'b0, 1'b0);
    run_wave("post_rst", 5, 5, 14 + FLT, 10, -1, -1, ncap, first);
    check("post_rst first", 64'(first), 64'(12 + FLT));

    // Table-driven waveforms
    for (int v = 0; v < 6; v++) begin
      prep(vecs[v].m, vecs[v].p);
      check({vecs[v].name, " irq cleared"}, irq, 1'b0);
      run_wave(vecs[v].name, vecs[v].hi, vecs[v].lo, vecs[v].n, vecs[v].exp_val,
               -1, -1, ncap, first);
      check({vecs[v].name, " ncap"}, 64'(ncap), 64'(vecs[v].exp_ncap));
      check({vecs[v].name, " first"}, 64'(first), 64'(vecs[v].exp_first));
      check({vecs[v].name, " irq"}, irq, 1'b1);
      check({vecs[v].name, " ovf"}, ovf, 1'b0);
      if (!vecs[v].m) check({vecs[v].name, " busy"}, busy, 1'b1);
    end

    // Overflow: one start edge, then no further edge
    prep(1'b0, 1'b0);
    ncap = 0;
    sig_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cap_valid) ncap++;
      if (i == 256 + FLT) begin
        check("ovf before", ovf, 1'b0);
        check("busy before ovf", busy, 1'b1);
      end
      if (i == 257 + FLT) begin
        check("ovf set", ovf, 1'b1);
        check("ovf irq", irq, 1'b1);
        check("ovf busy", busy, 1'b0);
      end
    end
    check("ovf no capture", 64'(ncap), 64'd0);

    // irq_clr alone clears both flags
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("clr irq", irq, 1'b0);
    check("clr ovf", ovf, 1'b0);

    // irq_clr coincident with a capture: set wins
    prep(1'b0, 1'b0);
    run_wave("clr_same", 5, 5, 13 + FLT, 10, 12 + FLT, -1, ncap, first);
    check("clr_same cap_valid", cap_valid, 1'b1);
    check("clr_same irq", irq, 1'b1);

    // en dropped for one cycle mid-measurement: that period is lost
    prep(1'b0, 1'b0);
    run_wave("abort", 5, 5, 35 + FLT, 10, -1, 15 + FLT, ncap, first);
    check("abort ncap", 64'(ncap), 64'd2);
    check("abort first", 64'(first), 64'(12 + FLT));

`ifdef INPUT_CAPTURE_FILTER_EN
    // A 2-cycle glitch never reaches the edge detector
    prep(1'b1, 1'b0);
    run_wave("glitch", 2, 40, 40, 2, -1, -1, ncap, first);
    check("glitch ncap", 64'(ncap), 64'd0);
    check("glitch busy", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
